// File: rtl/ins_fetch_if.sv
// Instruction-memory request/response bundle between the fetch stage and instruction memory.
// One request outstanding at a time: req/gnt accepts a request, rvalid returns its data.
interface ins_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/ins_fetch.sv
// Instruction fetch stage: holds the PC, fetches one word at a time from instruction memory and
// presents it to the decoder, honouring decoder stall and execute-stage redirects.
module ins_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst_n,
    ins_fetch_if.master      imem,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      pass_bits,
    output logic [31:0]      pc_out,
    output logic             ins_valid
);

    typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        stale_q, stale_d;
    logic        req_q, req_d;
    logic [31:0] pass_bits_q, pass_bits_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        ins_valid_q, ins_valid_d;

    logic [31:0] redirect_tgt;
    logic        gnt_ok;

    assign redirect_tgt = {redirect_pc[31:2], 2'b00};
    // A grant only counts while the request is actually being driven.
    assign gnt_ok       = imem.imem_gnt & req_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StReq;
            fetch_pc_q  <= RESET_PC;
            stale_q     <= 1'b0;
            req_q       <= 1'b0;
            pass_bits_q <= NOP_INSN;
            pc_out_q    <= 32'h0000_0000;
            ins_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            stale_q     <= stale_d;
            req_q       <= req_d;
            pass_bits_q <= pass_bits_d;
            pc_out_q    <= pc_out_d;
            ins_valid_q <= ins_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        stale_d    = stale_q;
        unique case (state_q)
            StReq: begin
                if (redirect) begin
                    fetch_pc_d = redirect_tgt;
                end
                if (gnt_ok) begin
                    state_d = StWait;
                    // The issued request was for the old PC; its response must be dropped.
                    if (redirect) begin
                        stale_d = 1'b1;
                    end
                end
            end
            StWait: begin
                if (imem.imem_rvalid) begin
                    if (stale_q || redirect) begin
                        stale_d = 1'b0;
                        state_d = StReq;
                        if (redirect) begin
                            fetch_pc_d = redirect_tgt;
                        end
                    end else begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = StHold;
                    end
                end else if (redirect) begin
                    stale_d    = 1'b1;
                    fetch_pc_d = redirect_tgt;
                end
            end
            StHold: begin
                if (redirect) begin
                    fetch_pc_d = redirect_tgt;
                    state_d    = StReq;
                end else if (!stall) begin
                    state_d = StReq;
                end
            end
            default: begin
                state_d = StReq;
            end
        endcase
    end

    always_comb begin
        req_d       = (state_d == StReq);
        pass_bits_d = pass_bits_q;
        pc_out_d    = pc_out_q;
        ins_valid_d = ins_valid_q;
        if (state_q == StWait && state_d == StHold) begin
            pass_bits_d = imem.imem_rdata;
            pc_out_d    = fetch_pc_q;
            ins_valid_d = 1'b1;
        end else if (state_q == StHold && state_d == StReq) begin
            pass_bits_d = NOP_INSN;
            ins_valid_d = 1'b0;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = fetch_pc_q;
    assign pass_bits      = pass_bits_q;
    assign pc_out         = pc_out_q;
    assign ins_valid      = ins_valid_q;

endmodule

// File: tb/tb_ins_fetch.sv
// Directed self-checking bench for ins_fetch: sequential fetch, stall, redirects, PC wrap, reset.
module tb_ins_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    ins_fetch_if bus_a ();
    ins_fetch_if bus_b ();

    logic        stall_a, redirect_a;
    logic [31:0] redirect_pc_a, pass_bits_a, pc_out_a;
    logic        ins_valid_a;
    logic [31:0] pass_bits_b, pc_out_b;
    logic        ins_valid_b;

    ins_fetch dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (bus_a.master),
        .stall       (stall_a),
        .redirect    (redirect_a),
        .redirect_pc (redirect_pc_a),
        .pass_bits   (pass_bits_a),
        .pc_out      (pc_out_a),
        .ins_valid   (ins_valid_a)
    );

    ins_fetch #(
        .RESET_PC (32'hFFFF_FFFC)
    ) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (bus_b.master),
        .stall       (1'b0),
        .redirect    (1'b0),
        .redirect_pc (32'h0000_0000),
        .pass_bits   (pass_bits_b),
        .pc_out      (pc_out_b),
        .ins_valid   (ins_valid_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic req, input logic [31:0] addr,
                         input logic [31:0] bits, input logic [31:0] pc, input logic vld);
        chk({tag, ".req"}, {31'd0, bus_a.imem_req}, {31'd0, req});
        chk({tag, ".addr"}, bus_a.imem_addr, addr);
        chk({tag, ".bits"}, pass_bits_a, bits);
        chk({tag, ".pc"}, pc_out_a, pc);
        chk({tag, ".vld"}, {31'd0, ins_valid_a}, {31'd0, vld});
    endtask

    task automatic chk_b(input string tag, input logic req, input logic [31:0] addr,
                         input logic [31:0] bits, input logic [31:0] pc, input logic vld);
        chk({tag, ".req"}, {31'd0, bus_b.imem_req}, {31'd0, req});
        chk({tag, ".addr"}, bus_b.imem_addr, addr);
        chk({tag, ".bits"}, pass_bits_b, bits);
        chk({tag, ".pc"}, pc_out_b, pc);
        chk({tag, ".vld"}, {31'd0, ins_valid_b}, {31'd0, vld});
    endtask

    initial begin
        bus_a.imem_gnt = 1'b0; bus_a.imem_rvalid = 1'b0; bus_a.imem_rdata = 32'h0;
        bus_b.imem_gnt = 1'b0; bus_b.imem_rvalid = 1'b0; bus_b.imem_rdata = 32'h0;
        stall_a = 1'b0; redirect_a = 1'b0; redirect_pc_a = 32'h0;

        // Reset values
        #12;
        chk_a("rst_a", 1'b0, 32'h0, NOP, 32'h0, 1'b0);
        chk_b("rst_b", 1'b0, 32'hFFFF_FFFC, NOP, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_a("first_req", 1'b1, 32'h0, NOP, 32'h0, 1'b0);

        // 1: immediate grant, data next cycle
        bus_a.imem_gnt = 1'b1;
        step();
        bus_a.imem_gnt = 1'b0;
        chk_a("t1_wait", 1'b0, 32'h0, NOP, 32'h0, 1'b0);
        bus_a.imem_rvalid = 1'b1; bus_a.imem_rdata = 32'h0050_0093;
        step();
        bus_a.imem_rvalid = 1'b0;
        chk_a("t1_hold", 1'b0, 32'h4, 32'h0050_0093, 32'h0, 1'b1);

        // 2: sequential fetches at 4 and 8
        step();
        chk_a("t2_req4", 1'b1, 32'h4, NOP, 32'h0, 1'b0);
        bus_a.imem_gnt = 1'b1;
        step();
        bus_a.imem_gnt = 1'b0;
        bus_a.imem_rvalid = 1'b1; bus_a.imem_rdata = 32'h00A0_0113;
        step();
        bus_a.imem_rvalid = 1'b0;
        chk_a("t2_hold4", 1'b0, 32'h8, 32'h00A0_0113, 32'h4, 1'b1);
        step();
        chk_a("t2_req8", 1'b1, 32'h8, NOP, 32'h4, 1'b0);
        bus_a.imem_gnt = 1'b1;
        step();
        bus_a.imem_gnt = 1'b0;
        bus_a.imem_rvalid = 1'b1; bus_a.imem_rdata = 32'h0020_8193;
        stall_a = 1'b1;
        step();
        bus_a.imem_rvalid = 1'b0;
        chk_a("t2_hold8", 1'b0, 32'hC, 32'h0020_8193, 32'h8, 1'b1);

        // 3: stall in HOLD; stray rvalid/gnt ignored
        for (int i = 0; i < 5; i++) begin
            bus_a.imem_rvalid = (i == 2);
            bus_a.imem_gnt    = (i == 3);
            bus_a.imem_rdata  = 32'hDEAD_BEEF;
            step();
            chk_a("t3_stall", 1'b0, 32'hC, 32'h0020_8193, 32'h8, 1'b1);
        end
        bus_a.imem_rvalid = 1'b0; bus_a.imem_gnt = 1'b0;
        stall_a = 1'b0;
        step();
        chk_a("t3_release", 1'b1, 32'hC, NOP, 32'h8, 1'b0);

        // 4: redirect during WAIT, returning data discarded
        bus_a.imem_gnt = 1'b1;
        step();
        bus_a.imem_gnt = 1'b0;
        redirect_a = 1'b1; redirect_pc_a = 32'h0000_0103;
        step();
        redirect_a = 1'b0;
        chk_a("t4_redir", 1'b0, 32'h100, NOP, 32'h8, 1'b0);
        bus_a.imem_rvalid = 1'b1; bus_a.imem_rdata = 32'hCAFE_F00D;
        step();
        bus_a.imem_rvalid = 1'b0;
        chk_a("t4_discard", 1'b1, 32'h100, NOP, 32'h8, 1'b0);

        // 5: redirect in the same cycle as gnt
        bus_a.imem_gnt = 1'b1;
        redirect_a = 1'b1; redirect_pc_a = 32'h0000_0200;
        step();
        bus_a.imem_gnt = 1'b0;
        redirect_a = 1'b0;
        chk_a("t5_wait", 1'b0, 32'h200, NOP, 32'h8, 1'b0);
        bus_a.imem_rvalid = 1'b1; bus_a.imem_rdata = 32'h1234_5678;
        step();
        bus_a.imem_rvalid = 1'b0;
        chk_a("t5_drop", 1'b1, 32'h200, NOP, 32'h8, 1'b0);
        bus_a.imem_gnt = 1'b1;
        step();
        bus_a.imem_gnt = 1'b0;
        bus_a.imem_rvalid = 1'b1; bus_a.imem_rdata = 32'h0010_0093;
        stall_a = 1'b1;
        step();
        bus_a.imem_rvalid = 1'b0;
        chk_a("t5_fetch", 1'b0, 32'h204, 32'h0010_0093, 32'h200, 1'b1);

        // Redirect in HOLD beats stall; redirect in REQ without gnt moves the address
        redirect_a = 1'b1; redirect_pc_a = 32'h0000_0301;
        step();
        chk_a("hold_redir", 1'b1, 32'h300, NOP, 32'h200, 1'b0);
        stall_a = 1'b0;
        redirect_pc_a = 32'h0000_0404;
        step();
        redirect_a = 1'b0;
        chk_a("req_redir", 1'b1, 32'h404, NOP, 32'h200, 1'b0);

        // 6: PC wrap on the second DUT, then reset mid-WAIT
        chk_b("t6_req", 1'b1, 32'hFFFF_FFFC, NOP, 32'h0, 1'b0);
        bus_b.imem_gnt = 1'b1;
        step();
        bus_b.imem_gnt = 1'b0;
        bus_b.imem_rvalid = 1'b1; bus_b.imem_rdata = 32'hAAAA_0013;
        step();
        bus_b.imem_rvalid = 1'b0;
        chk_b("t6_hold", 1'b0, 32'h0, 32'hAAAA_0013, 32'hFFFF_FFFC, 1'b1);
        step();
        chk_b("t6_wrap", 1'b1, 32'h0, NOP, 32'hFFFF_FFFC, 1'b0);
        bus_b.imem_gnt = 1'b1;
        step();
        bus_b.imem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_b("t6_rst", 1'b0, 32'hFFFF_FFFC, NOP, 32'h0, 1'b0);
        chk_a("t6_rst_a", 1'b0, 32'h0, NOP, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_b.imem_rvalid = 1'b1; bus_b.imem_rdata = 32'h5555_5555;
        step();
        bus_b.imem_rvalid = 1'b0;
        chk_b("t6_late_rvalid", 1'b1, 32'hFFFF_FFFC, NOP, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
